ysyx_2022040010_mul: RTL

//  Iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW, the multiply

---
 rtl/ysyx_2022040010_mul_pkg.sv | 31 +++
 rtl/ysyx_2022040010_mul.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_mul_pkg.sv
// Shared encodings and helpers for the iterative shift-add multiplier.
package ysyx_2022040010_mul_pkg;

    localparam int MUL_XLEN  = 64;
    localparam int MUL_CNT_W = 7;

    // FSM encodings, kept 2-bit so they line up with the divide unit's states
    typedef enum logic [1:0] {
        MUL_FREE = 2'b00,
        MUL_ON   = 2'b01,
        MUL_FIX  = 2'b10,
        MUL_END  = 2'b11
    } mul_state_e;

    // Result-select encodings
    localparam logic [1:0] MUL_SEL_LO = 2'b10;
    localparam logic [1:0] MUL_SEL_HI = 2'b01;

    localparam logic [MUL_XLEN-1:0] ZERO_WORD = '0;

    // Two's-complement negate of a single word (magnitude of a signed operand)
    function automatic logic [MUL_XLEN-1:0] neg_word(input logic [MUL_XLEN-1:0] v);
        return ~v + MUL_XLEN'(1);
    endfunction

    // Two's-complement negate of the full double-width product
    function automatic logic [2*MUL_XLEN-1:0] neg_dword(input logic [2*MUL_XLEN-1:0] v);
        return ~v + (2*MUL_XLEN)'(1);
    endfunction

endpackage

// File: rtl/ysyx_2022040010_mul.sv
// Iterative radix-2 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Works on operand magnitudes, fixes the sign at the end, and shares the
// start/annul/ready handshake of the divide unit.
module ysyx_2022040010_mul
    import ysyx_2022040010_mul_pkg::*;
#(
    parameter int XLEN  = MUL_XLEN,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            signed1_i,
    input  logic            signed2_i,
    input  logic            mul_32,
    input  logic [XLEN-1:0] opdata1_i,
    input  logic [XLEN-1:0] opdata2_i,
    input  logic            start_i,
    input  logic            annul_i,
    input  logic [1:0]      mul_res_sel,
    output logic [XLEN-1:0] mul_res_o,
    output logic            ready_o
);

    localparam int HALF = XLEN / 2;

    mul_state_e          state_reg,  state_next;
    logic [XLEN-1:0]     mcand_reg,  mcand_next;
    logic [XLEN-1:0]     mplier_reg, mplier_next;
    logic [2*XLEN-1:0]   prod_reg,   prod_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic                neg_reg,    neg_next;
    logic                m32_reg,    m32_next;
    logic                ready_reg,  ready_next;
    // armed_reg: start_i has been low since the last accepted request, so a
    // high start_i is a fresh request rather than a leftover from an annulled one
    logic                armed_reg,  armed_next;

    // Operand magnitudes and sign computed at request time
    logic [XLEN-1:0]     mag1, mag2;
    logic                neg_in;
    logic                accept;
    logic [XLEN:0]       sum;
    logic [CNT_W-1:0]    last_cnt;
    logic [XLEN-1:0]     w_sext;

    // Entry-side decode: magnitudes of the incoming operands
    always_comb begin
        mag1   = opdata1_i;
        mag2   = opdata2_i;
        neg_in = 1'b0;
        if (mul_32) begin
            mag1 = {{HALF{1'b0}}, opdata1_i[HALF-1:0]};
            mag2 = {{HALF{1'b0}}, opdata2_i[HALF-1:0]};
        end else begin
            if (signed1_i && opdata1_i[XLEN-1]) begin
                mag1 = neg_word(opdata1_i);
            end
            if (signed2_i && opdata2_i[XLEN-1]) begin
                mag2 = neg_word(opdata2_i);
            end
            neg_in = (signed1_i & opdata1_i[XLEN-1]) ^ (signed2_i & opdata2_i[XLEN-1]);
        end
    end

    assign accept   = start_i && !annul_i && armed_reg;
    // 65-bit partial sum keeps the carry out of the high half
    assign sum      = {1'b0, prod_reg[2*XLEN-1:XLEN]} +
                      (mplier_reg[0] ? {1'b0, mcand_reg} : {(XLEN+1){1'b0}});
    assign last_cnt = m32_reg ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);

    // Next-state and datapath update
    always_comb begin
        state_next  = state_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        prod_next   = prod_reg;
        cnt_next    = cnt_reg;
        neg_next    = neg_reg;
        m32_next    = m32_reg;
        ready_next  = ready_reg;
        armed_next  = armed_reg;

        if (!start_i) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            MUL_FREE: begin
                if (accept) begin
                    mcand_next  = mag1;
                    mplier_next = mag2;
                    neg_next    = neg_in;
                    m32_next    = mul_32;
                    cnt_next    = '0;
                    prod_next   = '0;
                    armed_next  = 1'b0;
                    if (mag1 == ZERO_WORD || mag2 == ZERO_WORD) begin
                        state_next = MUL_END;
                        ready_next = 1'b1;
                    end else begin
                        state_next = MUL_ON;
                    end
                end
            end
            MUL_ON: begin
                prod_next   = {sum, prod_reg[XLEN-1:1]};
                mplier_next = mplier_reg >> 1;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == last_cnt) begin
                    state_next = MUL_FIX;
                end
            end
            MUL_FIX: begin
                // A 32-bit run leaves the product HALF bits too high; realign it.
                if (m32_reg) begin
                    prod_next = prod_reg >> HALF;
                end else if (neg_reg) begin
                    prod_next = neg_dword(prod_reg);
                end
                state_next = MUL_END;
                ready_next = 1'b1;
            end
            MUL_END: begin
                if (!start_i) begin
                    state_next = MUL_FREE;
                    ready_next = 1'b0;
                end
            end
            default: begin
                state_next = MUL_FREE;
                ready_next = 1'b0;
            end
        endcase

        // A flush aborts any in-flight or completed-but-unconsumed operation
        if (annul_i && state_reg != MUL_FREE) begin
            state_next = MUL_FREE;
            ready_next = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= MUL_FREE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            m32_reg    <= 1'b0;
            ready_reg  <= 1'b0;
            armed_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            prod_reg   <= prod_next;
            cnt_reg    <= cnt_next;
            neg_reg    <= neg_next;
            m32_reg    <= m32_next;
            ready_reg  <= ready_next;
            armed_reg  <= armed_next;
        end
    end

    assign w_sext = {{HALF{prod_reg[HALF-1]}}, prod_reg[HALF-1:0]};

    // Result select tracks mul_res_sel combinationally; zero while not ready
    always_comb begin
        mul_res_o = ZERO_WORD;
        if (ready_reg) begin
            case (mul_res_sel)
                MUL_SEL_LO: mul_res_o = m32_reg ? w_sext : prod_reg[XLEN-1:0];
                MUL_SEL_HI: mul_res_o = m32_reg ? w_sext : prod_reg[2*XLEN-1:XLEN];
                default:    mul_res_o = ZERO_WORD;
            endcase
        end
    end

    assign ready_o = ready_reg;

endmodule
